// File: rtl/mr1_instr_mem.sv
// MR1 instruction-memory responder: one outstanding fetch, fixed-latency response,
// plus a side-band load port for preloading or patching the program image.
module mr1_instr_mem #(
    parameter int          DEPTH    = 1024,
    parameter int          LATENCY  = 1,
    parameter logic [31:0] OOR_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req_valid,
    output logic        instr_req_ready,
    input  logic [31:0] instr_req_addr,
    output logic        instr_rsp_valid,
    output logic [31:0] instr_rsp_data,
    input  logic        stall,
    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rsp_word_q, rsp_word_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic [31:0] mem [DEPTH];

    logic        req_in_range, load_in_range, accept;
    logic [31:0] fetch_word;
    logic        unused_bits;

    assign req_in_range  = {2'b00, instr_req_addr[31:2]} < 32'(DEPTH);
    assign load_in_range = {2'b00, load_addr[31:2]} < 32'(DEPTH);
    assign unused_bits   = &{1'b0, instr_req_addr[1:0], load_addr[1:0]};

    // Asynchronous read sees the pre-edge contents, so a same-edge load is not visible.
    assign fetch_word = req_in_range ? mem[instr_req_addr[AW+1:2]] : OOR_WORD;

    assign instr_req_ready = (state_q == IDLE || state_q == RESP) && !stall && !load_valid;
    assign accept          = instr_req_valid && instr_req_ready;
    assign instr_rsp_valid = (state_q == RESP);
    assign instr_rsp_data  = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_word_d = rsp_word_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    rsp_word_d = fetch_word;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        rsp_data_d = fetch_word;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Output data only moves on entry to RESP so it holds between pulses.
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    rsp_data_d = rsp_word_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rsp_word_q <= 32'd0;
            rsp_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_word_q <= rsp_word_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Program storage is deliberately not reset so an image survives a core reset.
    always_ff @(posedge clk) begin
        if (load_valid && load_in_range) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

endmodule

// File: tb/tb_mr1_instr_mem.sv
// Bench for mr1_instr_mem: a LATENCY=1 and a LATENCY=3 instance share clock, reset,
// stall and load port; expected responses go to per-instance queues checked by monitors.
module tb_mr1_instr_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, load_valid;
    logic [31:0] load_addr, load_data;
    logic        v1, v3, rdy1, rdy3, rv1, rv3;
    logic [31:0] a1, a3, rd1, rd3;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mr1_instr_mem #(.DEPTH(1024), .LATENCY(1), .OOR_WORD(32'h0000_0013)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .instr_req_valid(v1), .instr_req_ready(rdy1), .instr_req_addr(a1),
        .instr_rsp_valid(rv1), .instr_rsp_data(rd1),
        .stall(stall), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data)
    );

    mr1_instr_mem #(.DEPTH(1024), .LATENCY(3), .OOR_WORD(32'h0000_0013)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .instr_req_valid(v3), .instr_req_ready(rdy3), .instr_req_addr(a3),
        .instr_rsp_valid(rv3), .instr_rsp_data(rd3),
        .stall(stall), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: every rsp pulse must match the queue head, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rv1) begin
            if (q1.size() == 0) chk("spurious_rsp1", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("rsp1_data", rd1, e.data);
                chk("rsp1_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (q1.size() > 0 && cyc > q1[0].due) begin
            e = q1.pop_front();
            chk("missing_rsp1", 32'd0, 32'd1);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rv3) begin
            if (q3.size() == 0) chk("spurious_rsp3", 32'd1, 32'd0);
            else begin
                e = q3.pop_front();
                chk("rsp3_data", rd3, e.data);
                chk("rsp3_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (q3.size() > 0 && cyc > q3[0].due) begin
            e = q3.pop_front();
            chk("missing_rsp3", 32'd0, 32'd1);
        end
    end

    // All tasks start and end #1 after a rising edge.
    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int sel, input logic [31:0] addr, input logic [31:0] exp_d,
                         input int exp_wait, input bit push);
        int   w;
        exp_t e;
        w = 0;
        if (sel == 1) begin v1 = 1'b1; a1 = addr; end
        else          begin v3 = 1'b1; a3 = addr; end
        @(negedge clk);
        while (!((sel == 1) ? rdy1 : rdy3) && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk((sel == 1) ? "accept_wait1" : "accept_wait3", 32'(w), 32'(exp_wait));
        if (w < 40 && push) begin
            e.data = exp_d;
            e.due  = cyc + ((sel == 1) ? 1 : 3);
            if (sel == 1) q1.push_back(e);
            else          q3.push_back(e);
        end
        @(posedge clk); #1;
        if (sel == 1) v1 = 1'b0;
        else          v3 = 1'b0;
    endtask

    initial begin
        int guard;
        reset_n = 1'b0; stall = 1'b0; load_valid = 1'b0;
        load_addr = '0; load_data = '0;
        v1 = 1'b0; v3 = 1'b0; a1 = '0; a3 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid1", {31'd0, rv1}, 32'd0);
        chk("reset_rsp_valid3", {31'd0, rv3}, 32'd0);
        chk("reset_rsp_data1", rd1, 32'd0);
        chk("reset_rsp_data3", rd3, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ready1", {31'd0, rdy1}, 32'd1);
        chk("idle_ready3", {31'd0, rdy3}, 32'd1);
        @(posedge clk); #1;

        load(32'h0, 32'h0010_0093);
        load(32'h4, 32'h0020_0113);
        load(32'h8, 32'h0030_0193);
        settle();

        // LATENCY=1: single fetch, ready high in RESP, then back-to-back every cycle
        fetch(1, 32'h0, 32'h0010_0093, 0, 1'b1);
        @(negedge clk);
        chk("resp_ready1", {31'd0, rdy1}, 32'd1);
        @(posedge clk); #1;
        settle();
        fetch(1, 32'h0, 32'h0010_0093, 0, 1'b1);
        fetch(1, 32'h4, 32'h0020_0113, 0, 1'b1);
        fetch(1, 32'h8, 32'h0030_0193, 0, 1'b1);
        settle();

        // LATENCY=3: held valid accepts every 3 cycles, ready low for the 2 WAIT cycles
        fetch(3, 32'h0, 32'h0010_0093, 0, 1'b1);
        fetch(3, 32'h4, 32'h0020_0113, 2, 1'b1);
        fetch(3, 32'h8, 32'h0030_0193, 2, 1'b1);
        settle();

        // Out of range: NOP returned, load dropped (must not alias onto word 0)
        fetch(3, 32'h0000_1000, 32'h0000_0013, 0, 1'b1);
        settle();
        load(32'h0000_1000, 32'hDEAD_BEEF);
        settle();
        fetch(3, 32'h0, 32'h0010_0093, 0, 1'b1);
        settle();
        fetch(1, 32'h0000_1000, 32'h0000_0013, 0, 1'b1);
        fetch(1, 32'h0, 32'h0010_0093, 0, 1'b1);
        fetch(1, 32'hFFFF_FFFC, 32'h0000_0013, 0, 1'b1);
        settle();

        // Stall for 4 cycles with valid held
        fork
            begin stall = 1'b1; repeat (4) @(posedge clk); #1; stall = 1'b0; end
            fetch(3, 32'h4, 32'h0020_0113, 4, 1'b1);
        join
        settle();

        // Same-cycle load blocks ready; delayed accept sees the new word
        load(32'h4, 32'hAAAA_AAAA);
        fetch(3, 32'h4, 32'hAAAA_AAAA, 0, 1'b1);
        settle();
        fork
            load(32'h4, 32'h5555_5555);
            fetch(3, 32'h4, 32'h5555_5555, 1, 1'b1);
        join
        settle();

        // Load during WAIT does not disturb the pending response
        fork
            fetch(3, 32'h8, 32'h0030_0193, 0, 1'b1);
            begin @(posedge clk); #1; load(32'h8, 32'h1234_5678); end
        join
        settle();
        fetch(3, 32'h8, 32'h1234_5678, 0, 1'b1);
        settle();

        // Reset during WAIT drops the response; memory survives
        fetch(3, 32'h4, 32'h5555_5555, 0, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_rsp_valid3", {31'd0, rv3}, 32'd0);
        chk("midreset_rsp_data3", rd3, 32'd0);
        chk("midreset_ready3", {31'd0, rdy3}, 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        settle();
        fetch(3, 32'h4, 32'h5555_5555, 0, 1'b1);
        fetch(3, 32'h8, 32'h1234_5678, 2, 1'b1);
        @(negedge clk);
        chk("hold_data_before_rsp3", rd3, 32'h5555_5555);
        @(posedge clk); #1;
        settle();
        @(negedge clk);
        chk("hold_data_after_rsp3", rd3, 32'h1234_5678);

        guard = 0;
        while ((q1.size() > 0 || q3.size() > 0) && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        chk("queues_drained", 32'(q1.size() + q3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
